// File: rtl/uart_phase_streamer_pkg.sv
// Shared definitions for the phase streamer: serialiser state encoding, the
// burst header byte and the phase-to-grey saturating scaler.
package onn_uart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [7:0] HDR_BYTE = 8'hA5;

    function automatic logic [7:0] sat_grey(input logic [31:0] phi, input int shift);
        logic [63:0] tmp;
        tmp = {32'd0, phi} << shift;
        return (tmp > 64'd255) ? 8'hFF : tmp[7:0];
    endfunction

endpackage

// File: rtl/uart_phase_streamer_if.sv
// Host-facing bundle of the phase streamer: burst request, packed phases in;
// UART line, busy/done status and current phase index out.
interface uart_phase_streamer_if #(
    parameter int N     = 210,
    parameter int PHI_W = 4,
    parameter int IDX_W = 8
);
    logic                 transmit;
    logic [PHI_W*N-1:0]   phi_out;
    logic                 TxD;
    logic                 busy;
    logic                 done;
    logic [IDX_W-1:0]     idx;

    modport master (output transmit, phi_out, input TxD, busy, done, idx);
    modport slave  (input transmit, phi_out, output TxD, busy, done, idx);
endinterface

// File: rtl/uart_phase_streamer_tx_byte.sv
// 8N1 byte serialiser; a frame is 10*CLKS_PER_BIT cycles, TxD low the cycle after accept.
// Backpressure: ready only when idle or in the final stop-bit cycle, so frames chain with no gap.
module uart_tx_byte
    import onn_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_tx_vld,
    input  logic [7:0] i_tx_dat,
    output logic       o_tx_rdy,
    output logic       o_txd
);
    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_baud;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_txd;
    logic             w_bit_end;

    assign w_bit_end = (r_baud == CNT_LAST);
    assign o_tx_rdy  = (r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end);
    assign o_txd     = r_txd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
        end else begin
            if (r_state != ST_IDLE)
                r_baud <= w_bit_end ? '0 : r_baud + CNT_W'(1);
            case (r_state)
                ST_START: begin
                    if (w_bit_end) begin
                        r_state <= ST_DATA;
                        r_bit   <= '0;
                        r_txd   <= r_shift[0];
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit == 3'd7) begin
                            r_state <= ST_STOP;
                            r_txd   <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= r_shift >> 1;
                            r_txd   <= r_shift[1];
                        end
                    end
                end
                default: begin
                    // IDLE and the last stop-bit cycle share the accept path.
                    if (o_tx_rdy) begin
                        r_baud <= '0;
                        if (i_tx_vld) begin
                            r_state <= ST_START;
                            r_shift <= i_tx_dat;
                            r_txd   <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_txd   <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_phase_streamer.sv
// Streams N snapshotted phases as saturated grey bytes over 8N1, back to back; busy/done status.
// UART_PHASE_CHECKSUM_EN adds an 0xA5 header frame and a trailing XOR checksum frame.
module uart_phase_streamer
    import onn_uart_pkg::*;
#(
    parameter int N            = 210,
    parameter int PHI_W        = 4,
    parameter int CLKS_PER_BIT = 10416,
    parameter int SCALE_SHIFT  = 5,
    parameter int IDX_W        = 8
) (
    input logic                  clk,
    input logic                  reset,
    uart_phase_streamer_if.slave bus
);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    logic [PHI_W*N-1:0] r_shadow;
    logic [IDX_W-1:0]   r_idx;
    logic               r_busy;
    logic               r_done;
    logic               r_tq;

    logic               w_launch;
    logic               w_frame_end;
    logic               w_more;
    logic [IDX_W-1:0]   w_nxt_idx;
    logic               w_tx_vld;
    logic               w_tx_rdy;
    logic [7:0]         w_tx_dat;
    logic               w_txd;

    function automatic logic [7:0] grey_at(input logic [PHI_W*N-1:0] vec, input logic [IDX_W-1:0] i);
        return sat_grey(32'(vec[PHI_W*i +: PHI_W]), SCALE_SHIFT);
    endfunction

    assign w_launch    = bus.transmit & ~r_tq;
    assign w_frame_end = r_busy & w_tx_rdy;
    assign w_more      = (r_idx != IDX_LAST);
    assign w_nxt_idx   = w_more ? r_idx + IDX_W'(1) : r_idx;

`ifdef UART_PHASE_CHECKSUM_EN
    localparam logic [1:0] STG_HDR = 2'd0;
    localparam logic [1:0] STG_DAT = 2'd1;
    localparam logic [1:0] STG_SUM = 2'd2;

    logic [1:0] r_stage;
    logic [7:0] r_csum;
    logic [7:0] w_grey_nxt;

    assign w_grey_nxt = grey_at(r_shadow, (r_stage == STG_HDR) ? '0 : w_nxt_idx);

    always_comb begin
        w_tx_vld = 1'b0;
        w_tx_dat = HDR_BYTE;
        if (!r_busy) begin
            w_tx_vld = w_launch;
        end else if (w_frame_end && (r_stage != STG_SUM)) begin
            w_tx_vld = 1'b1;
            w_tx_dat = ((r_stage == STG_DAT) && !w_more) ? r_csum : w_grey_nxt;
        end
    end
`else
    // Frame 0 is launched in the same cycle the snapshot is taken, so its byte
    // comes from phi_out in that cycle, which is exactly what the shadow captures.
    always_comb begin
        w_tx_vld = 1'b0;
        w_tx_dat = r_busy ? grey_at(r_shadow, w_nxt_idx) : grey_at(bus.phi_out, '0);
        if (!r_busy)
            w_tx_vld = w_launch;
        else if (w_frame_end && w_more)
            w_tx_vld = 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tq     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_idx    <= '0;
            r_shadow <= '0;
`ifdef UART_PHASE_CHECKSUM_EN
            r_stage  <= STG_HDR;
            r_csum   <= '0;
`endif
        end else begin
            r_tq   <= bus.transmit;
            r_done <= 1'b0;
            if (!r_busy) begin
                if (w_launch) begin
                    r_shadow <= bus.phi_out;
                    r_idx    <= '0;
                    r_busy   <= 1'b1;
`ifdef UART_PHASE_CHECKSUM_EN
                    r_stage  <= STG_HDR;
                    r_csum   <= '0;
`endif
                end
            end else if (w_frame_end) begin
`ifdef UART_PHASE_CHECKSUM_EN
                case (r_stage)
                    STG_HDR: begin
                        r_stage <= STG_DAT;
                        r_csum  <= r_csum ^ w_grey_nxt;
                    end
                    STG_DAT: begin
                        if (w_more) begin
                            r_idx  <= w_nxt_idx;
                            r_csum <= r_csum ^ w_grey_nxt;
                        end else begin
                            r_stage <= STG_SUM;
                        end
                    end
                    default: begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end
                endcase
`else
                if (w_more) begin
                    r_idx <= w_nxt_idx;
                end else begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
`endif
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk      (clk),
        .reset    (reset),
        .i_tx_vld (w_tx_vld),
        .i_tx_dat (w_tx_dat),
        .o_tx_rdy (w_tx_rdy),
        .o_txd    (w_txd)
    );

    assign bus.TxD  = w_txd;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.idx  = r_idx;

endmodule

// File: tb/tb_uart_phase_streamer.sv
// Bench for uart_phase_streamer: scoreboarded burst decode, timing, snapshot and reset cases.
module tb_uart_phase_streamer;
    localparam int N       = 4;
    localparam int PHI_W   = 4;
    localparam int CPB     = 4;
    localparam int SHIFT   = 5;
    localparam int IDX_W   = 8;
    localparam int FRAME   = 10 * CPB;
`ifdef UART_PHASE_CHECKSUM_EN
    localparam int NF      = N + 2;
`else
    localparam int NF      = N;
`endif
    localparam int CAP_MAX = 512;

    typedef struct packed {
        logic [7:0]       dat;
        logic [IDX_W-1:0] idx;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks_total = 0;
    int   checks_passed = 0;
    exp_t exp_q[$];
    int   cur_ph[N];

    logic             txd_log  [CAP_MAX];
    logic             busy_log [CAP_MAX];
    logic             done_log [CAP_MAX];
    logic [IDX_W-1:0] idx_log  [CAP_MAX];

    uart_phase_streamer_if #(.N(N), .PHI_W(PHI_W), .IDX_W(IDX_W)) bus_if ();

    uart_phase_streamer #(
        .N(N), .PHI_W(PHI_W), .CLKS_PER_BIT(CPB), .SCALE_SHIFT(SHIFT), .IDX_W(IDX_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required < 200000", $time);
        $fatal(1, "watchdog");
    end

    function automatic int grey_model(input int phi);
        int v;
        v = phi * (2 ** SHIFT);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic set_phases(input int p0, input int p1, input int p2, input int p3);
        cur_ph[0] = p0; cur_ph[1] = p1; cur_ph[2] = p2; cur_ph[3] = p3;
        for (int i = 0; i < N; i++)
            bus_if.phi_out[PHI_W*i +: PHI_W] = PHI_W'(cur_ph[i]);
    endtask

    task automatic push_burst();
        int x;
        int g;
        x = 0;
`ifdef UART_PHASE_CHECKSUM_EN
        exp_q.push_back(exp_t'{dat: 8'hA5, idx: '0});
`endif
        for (int i = 0; i < N; i++) begin
            g = grey_model(cur_ph[i]);
            x = x ^ g;
            exp_q.push_back(exp_t'{dat: 8'(g), idx: IDX_W'(i)});
        end
`ifdef UART_PHASE_CHECKSUM_EN
        exp_q.push_back(exp_t'{dat: 8'(x), idx: IDX_W'(N - 1)});
`endif
    endtask

    // Sample 0 is taken just after the edge that samples the rising transmit.
    task automatic launch(input bit hold, input bit scramble);
        @(negedge clk);
        bus_if.transmit = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus_if.transmit = 1'b0;
        if (scramble) bus_if.phi_out = '1;
    endtask

    task automatic capture(input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            txd_log[k]  = bus_if.TxD;
            busy_log[k] = bus_if.busy;
            done_log[k] = bus_if.done;
            idx_log[k]  = bus_if.idx;
        end
    endtask

    task automatic decode_frame(input int f, output logic [9:0] fr, output logic [IDX_W-1:0] ix);
        for (int p = 0; p < 10; p++)
            fr[p] = txd_log[f*FRAME + p*CPB + CPB/2];
        ix = idx_log[f*FRAME + FRAME/2];
    endtask

    function automatic int find_done(input int ncap);
        for (int k = 0; k < ncap; k++)
            if (done_log[k] === 1'b1) return k;
        return -1;
    endfunction

    task automatic test_reset();
        bus_if.transmit = 1'b0;
        set_phases(0, 0, 0, 0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks_total++;
        if (bus_if.TxD !== 1'b1) $display("FAIL reset_txd: got %b expected 1", bus_if.TxD);
        else checks_passed++;
        checks_total++;
        if (bus_if.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus_if.busy);
        else checks_passed++;
        checks_total++;
        if (bus_if.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus_if.done);
        else checks_passed++;
        checks_total++;
        if (bus_if.idx !== '0) $display("FAIL reset_idx: got %0d expected 0", bus_if.idx);
        else checks_passed++;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic();
        logic [9:0] fr;
        logic [IDX_W-1:0] ix;
        exp_t e;
        int d;
        set_phases(0, 3, 7, 15);
        push_burst();
        launch(1'b0, 1'b0);
        capture(NF*FRAME + 20);
        for (int f = 0; f < NF; f++) begin
            decode_frame(f, fr, ix);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            checks_total++;
            if (fr !== {1'b1, e.dat, 1'b0} || ix !== e.idx)
                $display("FAIL basic_frame%0d: got frame %h idx %0d, expected byte %h idx %0d", f, fr, ix, e.dat, e.idx);
            else checks_passed++;
        end
        d = find_done(NF*FRAME + 20);
        checks_total++;
        if (d != NF*FRAME) $display("FAIL basic_done_time: got %0d cycles expected %0d", d, NF*FRAME);
        else checks_passed++;
        checks_total++;
        if (done_log[NF*FRAME + 1] !== 1'b0) $display("FAIL basic_done_pulse: done still %b one cycle later, expected 0", done_log[NF*FRAME + 1]);
        else checks_passed++;
        checks_total++;
        if (busy_log[NF*FRAME - 1] !== 1'b1 || busy_log[NF*FRAME] !== 1'b0)
            $display("FAIL basic_busy_fall: got %b%b expected 10", busy_log[NF*FRAME - 1], busy_log[NF*FRAME]);
        else checks_passed++;
        checks_total++;
        if (exp_q.size() != 0) $display("FAIL basic_queue: %0d frames left, expected 0", exp_q.size());
        else checks_passed++;
    endtask

    task automatic test_hold();
        logic [9:0] fr;
        logic [IDX_W-1:0] ix;
        exp_t e;
        int d;
        bit quiet;
        set_phases(1, 2, 3, 4);
        push_burst();
        launch(1'b1, 1'b0);
        capture(NF*FRAME + 60);
        for (int f = 0; f < NF; f++) begin
            decode_frame(f, fr, ix);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            checks_total++;
            if (fr !== {1'b1, e.dat, 1'b0} || ix !== e.idx)
                $display("FAIL hold_frame%0d: got frame %h idx %0d, expected byte %h idx %0d", f, fr, ix, e.dat, e.idx);
            else checks_passed++;
        end
        d = find_done(NF*FRAME + 60);
        checks_total++;
        if (d != NF*FRAME) $display("FAIL hold_done_time: got %0d expected %0d", d, NF*FRAME);
        else checks_passed++;
        quiet = 1'b1;
        for (int k = NF*FRAME; k < NF*FRAME + 60; k++)
            if (busy_log[k] !== 1'b0 || txd_log[k] !== 1'b1) quiet = 1'b0;
        checks_total++;
        if (!quiet) $display("FAIL hold_single_burst: line active after done while transmit held, expected idle");
        else checks_passed++;

        @(negedge clk);
        bus_if.transmit = 1'b0;
        repeat (3) @(posedge clk);
        push_burst();
        launch(1'b0, 1'b0);
        capture(NF*FRAME + 20);
        for (int f = 0; f < NF; f++) begin
            decode_frame(f, fr, ix);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            checks_total++;
            if (fr !== {1'b1, e.dat, 1'b0} || ix !== e.idx)
                $display("FAIL rearm_frame%0d: got frame %h idx %0d, expected byte %h idx %0d", f, fr, ix, e.dat, e.idx);
            else checks_passed++;
        end
        d = find_done(NF*FRAME + 20);
        checks_total++;
        if (d != NF*FRAME) $display("FAIL rearm_done_time: got %0d expected %0d", d, NF*FRAME);
        else checks_passed++;
    endtask

    task automatic test_snapshot();
        logic [9:0] fr;
        logic [IDX_W-1:0] ix;
        exp_t e;
        set_phases(1, 2, 3, 4);
        push_burst();
        launch(1'b0, 1'b1);
        capture(NF*FRAME + 20);
        for (int f = 0; f < NF; f++) begin
            decode_frame(f, fr, ix);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            checks_total++;
            if (fr !== {1'b1, e.dat, 1'b0} || ix !== e.idx)
                $display("FAIL snapshot_frame%0d: got frame %h idx %0d, expected byte %h idx %0d", f, fr, ix, e.dat, e.idx);
            else checks_passed++;
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] fr;
        logic [IDX_W-1:0] ix;
        exp_t e;
        int d;
        bit quiet;
        set_phases(5, 6, 7, 8);
        launch(1'b0, 1'b0);
        capture(2*FRAME + 4*CPB + 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks_total++;
        if (bus_if.TxD !== 1'b1 || bus_if.busy !== 1'b0)
            $display("FAIL midreset_line: got TxD %b busy %b expected 1 0", bus_if.TxD, bus_if.busy);
        else checks_passed++;
        checks_total++;
        if (bus_if.idx !== '0) $display("FAIL midreset_idx: got %0d expected 0", bus_if.idx);
        else checks_passed++;
        @(negedge clk);
        reset = 1'b0;
        capture(100);
        quiet = 1'b1;
        for (int k = 0; k < 100; k++)
            if (done_log[k] !== 1'b0 || busy_log[k] !== 1'b0 || txd_log[k] !== 1'b1) quiet = 1'b0;
        checks_total++;
        if (!quiet) $display("FAIL midreset_abandon: activity or done after reset, expected idle line and no done");
        else checks_passed++;

        push_burst();
        launch(1'b0, 1'b0);
        capture(NF*FRAME + 20);
        for (int f = 0; f < NF; f++) begin
            decode_frame(f, fr, ix);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            checks_total++;
            if (fr !== {1'b1, e.dat, 1'b0} || ix !== e.idx)
                $display("FAIL restart_frame%0d: got frame %h idx %0d, expected byte %h idx %0d", f, fr, ix, e.dat, e.idx);
            else checks_passed++;
        end
        d = find_done(NF*FRAME + 20);
        checks_total++;
        if (d != NF*FRAME) $display("FAIL restart_done_time: got %0d expected %0d", d, NF*FRAME);
        else checks_passed++;
    endtask

    task automatic test_saturate();
        logic [9:0] fr;
        logic [IDX_W-1:0] ix;
        exp_t e;
        set_phases(8, 7, 1, 0);
        push_burst();
        launch(1'b0, 1'b0);
        capture(NF*FRAME + 20);
        for (int f = 0; f < NF; f++) begin
            decode_frame(f, fr, ix);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            checks_total++;
            if (fr !== {1'b1, e.dat, 1'b0} || ix !== e.idx)
                $display("FAIL saturate_frame%0d: got frame %h idx %0d, expected byte %h idx %0d", f, fr, ix, e.dat, e.idx);
            else checks_passed++;
        end
    endtask

`ifdef UART_PHASE_CHECKSUM_EN
    task automatic test_checksum();
        logic [9:0] fr;
        logic [IDX_W-1:0] ix;
        exp_t e;
        int d;
        set_phases(1, 2, 3, 4);
        exp_q.push_back(exp_t'{dat: 8'hA5, idx: 8'd0});
        exp_q.push_back(exp_t'{dat: 8'h20, idx: 8'd0});
        exp_q.push_back(exp_t'{dat: 8'h40, idx: 8'd1});
        exp_q.push_back(exp_t'{dat: 8'h60, idx: 8'd2});
        exp_q.push_back(exp_t'{dat: 8'h80, idx: 8'd3});
        exp_q.push_back(exp_t'{dat: 8'h80, idx: 8'd3});
        launch(1'b0, 1'b0);
        capture(6*FRAME + 20);
        for (int f = 0; f < 6; f++) begin
            decode_frame(f, fr, ix);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            checks_total++;
            if (fr !== {1'b1, e.dat, 1'b0} || ix !== e.idx)
                $display("FAIL checksum_frame%0d: got frame %h idx %0d, expected byte %h idx %0d", f, fr, ix, e.dat, e.idx);
            else checks_passed++;
        end
        d = find_done(6*FRAME + 20);
        checks_total++;
        if (d != 6*FRAME) $display("FAIL checksum_done_time: got %0d expected %0d", d, 6*FRAME);
        else checks_passed++;
    endtask
`endif

    initial begin
        bus_if.transmit = 1'b0;
        bus_if.phi_out  = '0;
        test_reset();
        test_basic();
        test_hold();
        test_snapshot();
        test_reset_mid();
        test_saturate();
`ifdef UART_PHASE_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
